fetch_stage: RTL

//  IF stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. Owns the PC register and the

---
 rtl/fetch_stage_pkg.sv | 11 +
 rtl/fetch_stage_if_id_skid_buf.sv | 61 ++++++
 rtl/fetch_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the MIPS instruction-fetch stage: default widths, reset PC and bubble encoding.
package fetch_stage_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 32;
  localparam int unsigned DEF_INSTR_WIDTH   = 32;
  localparam logic [31:0] DEF_RESET_PC      = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [31:0] DEF_NOP_INSTR     = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES       = 4;

endpackage

// File: rtl/fetch_stage_if_id_skid_buf.sv
// IF/ID pipeline register with a one-entry hold buffer that parks a good word fetched while decode is stalled.
module if_id_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned INSTR_WIDTH   = DEF_INSTR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(DEF_NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     load,
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     hold_valid,
  output logic [INSTR_WIDTH-1:0]   instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d
);

  logic [INSTR_WIDTH-1:0]   hold_instr;
  logic [ADDRESS_WIDTH-1:0] hold_pc_plus4;

  // Priority: flush > stall (park new word) > drain buffer > load new word > bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid    <= 1'b0;
      hold_instr    <= NOP_INSTR;
      hold_pc_plus4 <= '0;
      instr_d       <= NOP_INSTR;
      pc_plus4_d    <= '0;
      valid_d       <= 1'b0;
    end else if (flush) begin
      hold_valid <= 1'b0;
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (stall) begin
      if (load) begin
        hold_valid    <= 1'b1;
        hold_instr    <= instr;
        hold_pc_plus4 <= pc_plus4;
      end
    end else if (hold_valid) begin
      hold_valid <= 1'b0;
      instr_d    <= hold_instr;
      pc_plus4_d <= hold_pc_plus4;
      valid_d    <= 1'b1;
    end else if (load) begin
      instr_d    <= instr;
      pc_plus4_d <= pc_plus4;
      valid_d    <= 1'b1;
    end else begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory request handshake, redirect handling and IF/ID fill.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned INSTR_WIDTH   = DEF_INSTR_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = ADDRESS_WIDTH'(DEF_RESET_PC),
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR = INSTR_WIDTH'(DEF_NOP_INSTR)
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_StallF,
  input  logic                     i_StallD,
  input  logic                     i_PCSrcD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCD,
  input  logic [INSTR_WIDTH-1:0]   i_IMemRdata,
  input  logic                     i_IMemReady,
  output logic                     o_IMemReq,
  output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
  output logic [ADDRESS_WIDTH-1:0] o_PCF,
  output logic [INSTR_WIDTH-1:0]   o_InstrD,
  output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
  output logic                     o_ValidD
);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] pend_pc;
  logic                     pend_valid;
  logic                     in_flight;
  logic                     hold_valid;
  logic                     accept;
  logic                     redir;
  logic                     good_word;

  // A started request is never withdrawn; a parked word blocks new requests.
  assign o_IMemReq  = in_flight | (~i_StallF & ~hold_valid);
  assign accept     = o_IMemReq & i_IMemReady;
  assign redir      = i_PCSrcD & ~i_StallD;
  assign good_word  = accept & ~redir & ~pend_valid;
  assign pc_plus4   = pc + ADDRESS_WIDTH'(INSTR_BYTES);
  assign o_IMemAddr = pc;
  assign o_PCF      = pc;

  // Redirects arriving mid-wait are deferred so the address stays stable until the accept.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= o_IMemReq & ~i_IMemReady;
      if (redir && in_flight && !i_IMemReady) begin
        pend_valid <= 1'b1;
        pend_pc    <= i_PCD;
      end else if (redir) begin
        pc         <= i_PCD;
        pend_valid <= 1'b0;
      end else if (accept && pend_valid) begin
        pc         <= pend_pc;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pc <= pc_plus4;
      end
    end
  end

  if_id_skid_buf #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .INSTR_WIDTH   (INSTR_WIDTH),
    .NOP_INSTR     (NOP_INSTR)
  ) u_skid (
    .clk        (i_CLK),
    .rst        (i_RST),
    .flush      (redir),
    .stall      (i_StallD),
    .load       (good_word),
    .instr      (i_IMemRdata),
    .pc_plus4   (pc_plus4),
    .hold_valid (hold_valid),
    .instr_d    (o_InstrD),
    .pc_plus4_d (o_PCPlus4D),
    .valid_d    (o_ValidD)
  );

  // Hazard unit never stalls decode without also stalling fetch.
  assert property (@(posedge i_CLK) disable iff (i_RST) !(i_StallD && !i_StallF));

endmodule
